// File: rtl/atm_pkg.sv
// atm_pkg: state, op and action encodings shared by the ATM session controller.
package atm_pkg;
  typedef logic [3:0] state_t;
  localparam state_t S_IDLE   = 4'd0;
  localparam state_t S_CHK    = 4'd1;
  localparam state_t S_PIN    = 4'd2;
  localparam state_t S_MENU   = 4'd3;
  localparam state_t S_AMT    = 4'd4;
  localparam state_t S_EXEC   = 4'd5;
  localparam state_t S_REPORT = 4'd6;
  localparam state_t S_EJECT  = 4'd7;
  localparam state_t S_RETAIN = 4'd8;
  typedef enum logic [1:0] {OP_DEP = 2'b00, OP_WDR = 2'b01, OP_BAL = 2'b10, OP_EXIT = 2'b11} op_t;
  localparam logic [4:0] ACT_IDLE   = 5'd0;
  localparam logic [4:0] ACT_CHK    = 5'd1;
  localparam logic [4:0] ACT_PIN    = 5'd2;
  localparam logic [4:0] ACT_MENU   = 5'd3;
  localparam logic [4:0] ACT_AMT    = 5'd4;
  localparam logic [4:0] ACT_EXEC   = 5'd5;
  localparam logic [4:0] ACT_REPORT = 5'd6;
  localparam logic [4:0] ACT_EJECT  = 5'd7;
  localparam logic [4:0] ACT_RETAIN = 5'd8;
  // State codes are chosen to coincide with their action codes.
  function automatic logic [4:0] act_of(state_t s);
    return {1'b0, s};
  endfunction
endpackage

// File: rtl/atm_timeout_ctr.sv
// atm_timeout_ctr: inactivity down-counter; expired once N-1 enabled cycles pass since clear.
module atm_timeout_ctr #(
  parameter int N = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);
  localparam int W = $clog2(N);
  localparam logic [W-1:0] LOAD = W'(N - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= LOAD;
    else if (clr) cnt <= LOAD;
    else if (en && cnt != '0) cnt <= cnt - 1'b1;
  assign expired = cnt == '0;
endmodule

// File: rtl/atm_session_ctrl.sv
// atm_session_ctrl: card/PIN/menu session FSM with balance register and inactivity timeout.
module atm_session_ctrl
  import atm_pkg::*;
#(
  parameter int PIN_W       = 4,
  parameter int BAL_W       = 16,
  parameter int MAX_TRIES   = 3,
  parameter int TIMEOUT_CYC = 1000,
  parameter int INIT_BAL    = 100
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             card_in,
  input  logic                             card_valid,
  input  logic [PIN_W-1:0]                 card_pin,
  input  logic                             pin_vld,
  input  logic [PIN_W-1:0]                 pin_in,
  input  logic                             op_vld,
  input  logic [1:0]                       op_sel,
  input  logic                             amt_vld,
  input  logic [BAL_W-1:0]                 amt_in,
  input  logic                             cancel,
  output logic [4:0]                       action,
  output logic [BAL_W-1:0]                 balance,
  output logic [$clog2(MAX_TRIES+1)-1:0]   tries_left,
  output logic                             done,
  output logic                             err
);
  localparam int TW = $clog2(MAX_TRIES + 1);
  state_t state, state_n;
  logic [PIN_W-1:0] pin_q;
  logic [1:0] op_q;
  logic [BAL_W-1:0] amt_q;
  logic [BAL_W:0] sum;
  logic wait_st, abort, accept, expired, timeout, pin_ok, last_try, exec_bad;
  assign wait_st  = state inside {S_PIN, S_MENU, S_AMT};
  // A pulled card aborts exactly like cancel, and only where cancel is honoured.
  assign abort    = (cancel || !card_in) && (wait_st || state == S_CHK);
  assign accept   = (state == S_PIN && pin_vld) || (state == S_MENU && op_vld) || (state == S_AMT && amt_vld);
  assign timeout  = wait_st && expired && !abort && !accept;
  assign pin_ok   = pin_in == pin_q;
  assign last_try = tries_left == TW'(1);
  assign sum      = {1'b0, balance} + {1'b0, amt_q};
  assign exec_bad = (op_q == OP_DEP) ? sum[BAL_W] : (amt_q > balance);
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:   state_n = card_in ? S_CHK : S_IDLE;
      S_CHK:    state_n = (abort || !card_valid) ? S_EJECT : S_PIN;
      S_PIN:    state_n = abort ? S_EJECT : pin_vld ? (pin_ok ? S_MENU : last_try ? S_RETAIN : S_PIN)
                        : expired ? S_EJECT : S_PIN;
      S_MENU:   state_n = abort ? S_EJECT
                        : op_vld ? (op_sel == OP_BAL ? S_REPORT : op_sel == OP_EXIT ? S_EJECT : S_AMT)
                        : expired ? S_EJECT : S_MENU;
      S_AMT:    state_n = abort ? S_EJECT : amt_vld ? S_EXEC : expired ? S_EJECT : S_AMT;
      S_EXEC:   state_n = S_REPORT;
      S_REPORT: state_n = S_MENU;
      S_EJECT:  state_n = card_in ? S_EJECT : S_IDLE;
      S_RETAIN: state_n = S_RETAIN;
      default:  state_n = S_IDLE;
    endcase
  end
  atm_timeout_ctr #(.N(TIMEOUT_CYC)) u_tmo (
    .clk(clk), .rst_n(rst_n), .clr(state_n != state || accept || !wait_st), .en(wait_st), .expired(expired)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state      <= S_IDLE;
      action     <= ACT_IDLE;
      balance    <= INIT_BAL[BAL_W-1:0];
      tries_left <= MAX_TRIES[TW-1:0];
      done       <= 1'b0;
      err        <= 1'b0;
      pin_q      <= '0;
      op_q       <= '0;
      amt_q      <= '0;
    end else begin
      state  <= state_n;
      action <= act_of(state_n);
      done   <= (state == S_MENU && !abort && op_vld && op_sel == OP_BAL) || (state == S_EXEC && !exec_bad);
      err    <= timeout || (state == S_EXEC && exec_bad);
      if (state == S_CHK) pin_q <= card_pin;
      if (state == S_MENU && op_vld) op_q <= op_sel;
      if (state == S_AMT && amt_vld) amt_q <= amt_in;
      if (state == S_PIN && pin_vld && !abort) tries_left <= pin_ok ? MAX_TRIES[TW-1:0] : tries_left - 1'b1;
      if (state == S_EXEC && !exec_bad) balance <= (op_q == OP_DEP) ? sum[BAL_W-1:0] : balance - amt_q;
    end
endmodule

// File: tb/tb_atm_session_ctrl.sv
// tb_atm_session_ctrl: directed scenario tests for atm_session_ctrl (16-bit and 8-bit balance builds).
module tb_atm_session_ctrl;
  logic clk = 1'b0, rst_n = 1'b0;
  logic card_in = 0, card_valid = 0, pin_vld = 0, op_vld = 0, amt_vld = 0, cancel = 0;
  logic [3:0] card_pin = 0, pin_in = 0;
  logic [1:0] op_sel = 0;
  logic [15:0] amt_in = 0;
  logic [4:0] action, action2;
  logic [15:0] balance;
  logic [7:0] balance2;
  logic [1:0] tries_left, tries2;
  logic done, err, done2, err2;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  atm_session_ctrl #(.PIN_W(4), .BAL_W(16), .MAX_TRIES(3), .TIMEOUT_CYC(8), .INIT_BAL(100)) dut (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_valid(card_valid), .card_pin(card_pin),
    .pin_vld(pin_vld), .pin_in(pin_in), .op_vld(op_vld), .op_sel(op_sel), .amt_vld(amt_vld),
    .amt_in(amt_in), .cancel(cancel), .action(action), .balance(balance), .tries_left(tries_left),
    .done(done), .err(err));

  atm_session_ctrl #(.PIN_W(4), .BAL_W(8), .MAX_TRIES(3), .TIMEOUT_CYC(8), .INIT_BAL(250)) dut2 (
    .clk(clk), .rst_n(rst_n), .card_in(card_in), .card_valid(card_valid), .card_pin(card_pin),
    .pin_vld(pin_vld), .pin_in(pin_in), .op_vld(op_vld), .op_sel(op_sel), .amt_vld(amt_vld),
    .amt_in(amt_in[7:0]), .cancel(cancel), .action(action2), .balance(balance2), .tries_left(tries2),
    .done(done2), .err(err2));

  task automatic tick(int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    {card_in, card_valid, pin_vld, op_vld, amt_vld, cancel} = '0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic start_session(input logic [3:0] p);
    card_in = 1; card_valid = 1; card_pin = p;
    tick(2);
  endtask

  task automatic enter_pin(input logic [3:0] p);
    pin_vld = 1; pin_in = p;
    tick();
    pin_vld = 0;
  endtask

  task automatic choose(input logic [1:0] o);
    op_vld = 1; op_sel = o;
    tick();
    op_vld = 0;
  endtask

  task automatic give_amt(input logic [15:0] a);
    amt_vld = 1; amt_in = a;
    tick();
    amt_vld = 0;
  endtask

  task automatic end_session();
    choose(2'b11);
    card_in = 0;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (action !== 5'd0) $display("FAIL reset_action: got %0d expected 0", action); else passed++;
    total++; if (balance !== 16'd100) $display("FAIL reset_balance: got %0d expected 100", balance); else passed++;
    total++; if (balance2 !== 8'd250) $display("FAIL reset_balance8: got %0d expected 250", balance2); else passed++;
    total++; if (tries_left !== 2'd3) $display("FAIL reset_tries: got %0d expected 3", tries_left); else passed++;
    total++; if ({done, err} !== 2'b00) $display("FAIL reset_pulses: got %b expected 00", {done, err}); else passed++;
  endtask

  task automatic test_deposit();
    start_session(4'hF);
    total++; if (action !== 5'd2) $display("FAIL dep_pin_wait: got %0d expected 2", action); else passed++;
    enter_pin(4'hF);
    total++; if (action !== 5'd3) $display("FAIL dep_menu: got %0d expected 3", action); else passed++;
    choose(2'b00);
    total++; if (action !== 5'd4) $display("FAIL dep_amt_wait: got %0d expected 4", action); else passed++;
    give_amt(16'd25);
    total++; if (action !== 5'd5) $display("FAIL dep_exec: got %0d expected 5", action); else passed++;
    tick();
    total++; if ({done, err} !== 2'b10) $display("FAIL dep_done: got %b expected 10", {done, err}); else passed++;
    total++; if (balance !== 16'd125) $display("FAIL dep_balance: got %0d expected 125", balance); else passed++;
    total++; if (action !== 5'd6) $display("FAIL dep_report: got %0d expected 6", action); else passed++;
    tick();
    total++; if (action !== 5'd3 || done !== 1'b0) $display("FAIL dep_back_menu: got %0d/%b expected 3/0", action, done); else passed++;
    choose(2'b11);
    total++; if (action !== 5'd7) $display("FAIL dep_exit_eject: got %0d expected 7", action); else passed++;
    card_in = 0;
    tick();
    total++; if (action !== 5'd0) $display("FAIL dep_idle: got %0d expected 0", action); else passed++;
  endtask

  task automatic test_withdraw();
    do_reset();
    start_session(4'hF);
    enter_pin(4'hF);
    choose(2'b01);
    give_amt(16'd101);
    tick();
    total++; if ({done, err} !== 2'b01) $display("FAIL wdr_over_err: got %b expected 01", {done, err}); else passed++;
    total++; if (balance !== 16'd100) $display("FAIL wdr_over_bal: got %0d expected 100", balance); else passed++;
    tick();
    choose(2'b01);
    give_amt(16'd100);
    tick();
    total++; if ({done, err} !== 2'b10) $display("FAIL wdr_exact_done: got %b expected 10", {done, err}); else passed++;
    total++; if (balance !== 16'd0) $display("FAIL wdr_exact_bal: got %0d expected 0", balance); else passed++;
    tick();
    choose(2'b10);
    total++; if (done !== 1'b1 || action !== 5'd6) $display("FAIL bal_query: got %b/%0d expected 1/6", done, action); else passed++;
    tick();
    end_session();
  endtask

  task automatic test_overflow();
    do_reset();
    start_session(4'hF);
    enter_pin(4'hF);
    choose(2'b00);
    give_amt(16'd6);
    tick();
    total++; if ({done2, err2} !== 2'b01) $display("FAIL ovf_err: got %b expected 01", {done2, err2}); else passed++;
    total++; if (balance2 !== 8'd250) $display("FAIL ovf_bal: got %0d expected 250", balance2); else passed++;
    tick();
    choose(2'b00);
    give_amt(16'd5);
    tick();
    total++; if ({done2, err2} !== 2'b10) $display("FAIL max_done: got %b expected 10", {done2, err2}); else passed++;
    total++; if (balance2 !== 8'd255) $display("FAIL max_bal: got %0d expected 255", balance2); else passed++;
    total++; if (balance !== 16'd111) $display("FAIL wide_bal: got %0d expected 111", balance); else passed++;
    tick();
    end_session();
  endtask

  task automatic test_wrong_pin();
    do_reset();
    start_session(4'hF);
    enter_pin(4'hC);
    total++; if (tries_left !== 2'd2 || action !== 5'd2) $display("FAIL pin_try1: got %0d/%0d expected 2/2", tries_left, action); else passed++;
    enter_pin(4'hC);
    total++; if (tries_left !== 2'd1 || action !== 5'd2) $display("FAIL pin_try2: got %0d/%0d expected 1/2", tries_left, action); else passed++;
    enter_pin(4'hC);
    total++; if (tries_left !== 2'd0 || action !== 5'd8) $display("FAIL pin_retain: got %0d/%0d expected 0/8", tries_left, action); else passed++;
    card_in = 0;
    tick(3);
    card_in = 1;
    tick(2);
    total++; if (action !== 5'd8) $display("FAIL retain_hold: got %0d expected 8", action); else passed++;
    rst_n = 0;
    #1;
    total++; if (action !== 5'd0 || tries_left !== 2'd3) $display("FAIL async_reset: got %0d/%0d expected 0/3", action, tries_left); else passed++;
    card_in = 0;
    tick();
    rst_n = 1;
  endtask

  task automatic test_timeout();
    do_reset();
    start_session(4'hF);
    enter_pin(4'hF);
    tick(7);
    total++; if (action !== 5'd3 || err !== 1'b0) $display("FAIL tmo_before: got %0d/%b expected 3/0", action, err); else passed++;
    tick();
    total++; if (action !== 5'd7 || err !== 1'b1) $display("FAIL tmo_eject: got %0d/%b expected 7/1", action, err); else passed++;
    card_in = 0;
    tick();
    total++; if (action !== 5'd0 || err !== 1'b0) $display("FAIL tmo_idle: got %0d/%b expected 0/0", action, err); else passed++;
    start_session(4'hF);
    tick(4);
    enter_pin(4'hC);
    tick(3);
    total++; if (action !== 5'd2) $display("FAIL tmo_restart_early: got %0d expected 2", action); else passed++;
    tick(4);
    total++; if (action !== 5'd2 || err !== 1'b0) $display("FAIL tmo_restart_hold: got %0d/%b expected 2/0", action, err); else passed++;
    tick();
    total++; if (action !== 5'd7 || err !== 1'b1) $display("FAIL tmo_restart_eject: got %0d/%b expected 7/1", action, err); else passed++;
    total++; if (tries_left !== 2'd2) $display("FAIL tmo_tries: got %0d expected 2", tries_left); else passed++;
    card_in = 0;
    tick();
  endtask

  task automatic test_cancel();
    do_reset();
    start_session(4'hF);
    enter_pin(4'hF);
    choose(2'b00);
    cancel = 1; amt_vld = 1; amt_in = 16'd50;
    tick();
    cancel = 0; amt_vld = 0;
    total++; if (action !== 5'd7) $display("FAIL cancel_eject: got %0d expected 7", action); else passed++;
    tick(2);
    total++; if (balance !== 16'd100 || done !== 1'b0) $display("FAIL cancel_bal: got %0d/%b expected 100/0", balance, done); else passed++;
    card_in = 0;
    tick();
    total++; if (action !== 5'd0) $display("FAIL cancel_idle: got %0d expected 0", action); else passed++;
    start_session(4'hF);
    card_in = 0;
    tick();
    total++; if (action !== 5'd7) $display("FAIL pull_eject: got %0d expected 7", action); else passed++;
    tick();
    total++; if (action !== 5'd0) $display("FAIL pull_idle: got %0d expected 0", action); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not end within time limit");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_deposit();
    test_withdraw();
    test_overflow();
    test_wrong_pin();
    test_timeout();
    test_cancel();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
